// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for the five-stage core.
//   Merges per-stage stall requests into a per-stage freeze vector.
//   Registers taken branches resolved in ID and issues a one-shot PC redirect
//   with an IF squash, tracking the MIPS delay slot.
//   Exception/ERET flushes override everything.
//
// Ports:
//   clk, rst           core clock (rising edge), asynchronous active-high reset
//   branch_flag/addr   taken branch/jump from ID and its target
//   stall_req_*        stall requests from IF, ID (load-use), EX (multi-cycle), MEM
//   exc_req, eret_req  exception / ERET committed in MEM; epc valid with eret_req
//   stall[5:0]         freeze enables: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=0
//   flush              clear all pipeline registers this edge
//   flush_if           clear IF/ID this edge (wrong-path squash)
//   redirect_en/addr   PC loads redirect_addr this edge (addr is 0 when not enabled)
//   in_delay_slot      instruction now in ID is a branch delay slot
//
// Redirect handshake: redirect_en is a valid that stays high with a constant
// redirect_addr until it is consumed. In BR_PEND the consuming edge is the
// first one with stall[0]=0. In EXC_FLUSH the request always lasts exactly one cycle.
module pipeline_ctrl #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              stall_req_if,
  input  logic              stall_req_id,
  input  logic              stall_req_ex,
  input  logic              stall_req_mem,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              flush_if,
  output logic              redirect_en,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              in_delay_slot
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BR_PEND   = 2'd1,
    EXC_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              ds_q, ds_d;
  logic [5:0]        stall_raw;

  // The deepest stalled stage freezes itself and everything upstream of it.
  always_comb begin
    stall_raw = 6'b000000;
    if (stall_req_mem)     stall_raw = 6'b011111;
    else if (stall_req_ex) stall_raw = 6'b001111;
    else if (stall_req_id) stall_raw = 6'b000111;
    else if (stall_req_if) stall_raw = 6'b000011;
  end

  // Outputs depend only on the state and the current stall requests.
  always_comb begin
    stall         = stall_raw;
    flush         = 1'b0;
    flush_if      = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = '0;
    unique case (state_q)
      RUN: ;
      BR_PEND: begin
        redirect_en   = 1'b1;
        redirect_addr = target_q;
        // Squash the branch+8 fetch only on the edge that takes the redirect.
        flush_if      = ~stall_raw[0];
      end
      EXC_FLUSH: begin
        stall         = 6'b000000;
        flush         = 1'b1;
        flush_if      = 1'b1;
        redirect_en   = 1'b1;
        redirect_addr = target_q;
      end
      default: ;
    endcase
  end

  assign in_delay_slot = ds_q;

  // Next-state. A single target register serves both branch and exception
  // redirects, because an exception discards any pending branch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ds_d     = ds_q;
    if (!stall[2]) ds_d = 1'b0;
    if (exc_req || eret_req) begin
      state_d  = EXC_FLUSH;
      target_d = exc_req ? EXC_VECTOR : epc;
      ds_d     = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          // While ID/EX is frozen, ID holds the branch and presents it again later.
          if (branch_flag && !stall[2]) begin
            state_d  = BR_PEND;
            target_d = branch_addr;
            ds_d     = 1'b1;
          end
        end
        BR_PEND: begin
          // branch_flag is ignored here, so a branch in the delay slot is dropped.
          if (!stall[0]) state_d = RUN;
        end
        EXC_FLUSH: state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      target_q <= '0;
      ds_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ds_q     <= ds_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_addr;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        exc_req, eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush, flush_if, redirect_en, in_delay_slot;
  logic [31:0] redirect_addr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] EXC_VEC = 32'hBFC00380;

  pipeline_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .branch_flag   (branch_flag),
    .branch_addr   (branch_addr),
    .stall_req_if  (stall_req_if),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_req       (exc_req),
    .eret_req      (eret_req),
    .epc           (epc),
    .stall         (stall),
    .flush         (flush),
    .flush_if      (flush_if),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .in_delay_slot (in_delay_slot)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move just past the next rising edge; inputs are then changed there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".redirect_en"},   {31'd0, redirect_en}, 32'd0);
    check({tag, ".redirect_addr"}, redirect_addr, 32'd0);
    check({tag, ".flush"},         {31'd0, flush}, 32'd0);
    check({tag, ".flush_if"},      {31'd0, flush_if}, 32'd0);
  endtask

  task automatic check_redirect(input string tag, input logic [31:0] addr,
                                input logic exp_flush, input logic exp_flush_if);
    check({tag, ".redirect_en"},   {31'd0, redirect_en}, 32'd1);
    check({tag, ".redirect_addr"}, redirect_addr, addr);
    check({tag, ".flush"},         {31'd0, flush}, {31'd0, exp_flush});
    check({tag, ".flush_if"},      {31'd0, flush_if}, {31'd0, exp_flush_if});
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    branch_flag = 0; branch_addr = '0;
    stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
    exc_req = 0; eret_req = 0; epc = '0;
    #2;
    check_idle("reset");
    check("reset.stall", {26'd0, stall}, 32'd0);
    check("reset.ds", {31'd0, in_delay_slot}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();
    check_idle("idle");
    check("idle.stall", {26'd0, stall}, 32'd0);

    // Stall priority
    stall_req_id = 1; stall_req_mem = 1; #1;
    check("prio.mem_id", {26'd0, stall}, 32'b011111);
    stall_req_mem = 0; #1;
    check("prio.id", {26'd0, stall}, 32'b000111);
    stall_req_id = 0; stall_req_if = 1; #1;
    check("prio.if", {26'd0, stall}, 32'b000011);
    stall_req_ex = 1; #1;
    check("prio.ex_if", {26'd0, stall}, 32'b001111);
    stall_req_ex = 0; stall_req_if = 0;
    step();

    // Branch with no stall
    branch_flag = 1; branch_addr = 32'h0000_1040;
    step();
    branch_flag = 0; #1;
    check_redirect("br", 32'h0000_1040, 1'b0, 1'b1);
    check("br.ds", {31'd0, in_delay_slot}, 32'd1);
    step(); #1;
    check_idle("br_done");
    check("br_done.ds", {31'd0, in_delay_slot}, 32'd0);

    // Branch with fetch stall for three cycles; a second branch is ignored
    branch_flag = 1; branch_addr = 32'h0000_2000;
    step();
    branch_flag = 0; stall_req_if = 1; #1;
    check_redirect("fs1", 32'h0000_2000, 1'b0, 1'b0);
    check("fs1.ds", {31'd0, in_delay_slot}, 32'd1);
    check("fs1.stall", {26'd0, stall}, 32'b000011);
    step();
    branch_flag = 1; branch_addr = 32'h0000_3000; #1;
    check_redirect("fs2", 32'h0000_2000, 1'b0, 1'b0);
    check("fs2.ds", {31'd0, in_delay_slot}, 32'd0);
    step();
    branch_flag = 0; #1;
    check_redirect("fs3", 32'h0000_2000, 1'b0, 1'b0);
    step();
    stall_req_if = 0; #1;
    check_redirect("fs4", 32'h0000_2000, 1'b0, 1'b1);
    step(); #1;
    check_idle("fs_done");
    step(); #1;
    check_idle("fs_ignored");

    // Branch while ID is stalled
    branch_flag = 1; branch_addr = 32'h0000_4000; stall_req_id = 1; #1;
    check("ids.stall", {26'd0, stall}, 32'b000111);
    step(); #1;
    check_idle("ids1");
    check("ids1.ds", {31'd0, in_delay_slot}, 32'd0);
    step();
    stall_req_id = 0; #1;
    check_idle("ids2");
    step();
    branch_flag = 0; #1;
    check_redirect("ids_acc", 32'h0000_4000, 1'b0, 1'b1);
    check("ids_acc.ds", {31'd0, in_delay_slot}, 32'd1);
    step(); #1;
    check_idle("ids_done");

    // Exception while a branch is pending, with a MEM stall
    branch_flag = 1; branch_addr = 32'h0000_5000;
    step();
    branch_flag = 0; exc_req = 1; stall_req_mem = 1; #1;
    check_redirect("exb_pend", 32'h0000_5000, 1'b0, 1'b0);
    step();
    exc_req = 0; #1;
    check_redirect("exb", EXC_VEC, 1'b1, 1'b1);
    check("exb.stall", {26'd0, stall}, 32'd0);
    check("exb.ds", {31'd0, in_delay_slot}, 32'd0);
    step(); #1;
    check_idle("exb_after");
    check("exb_after.stall", {26'd0, stall}, 32'b011111);
    stall_req_mem = 0;
    step(); #1;
    check_idle("exb_no_branch");

    // ERET
    eret_req = 1; epc = 32'h8000_0200;
    step();
    eret_req = 0; #1;
    check_redirect("eret", 32'h8000_0200, 1'b1, 1'b1);
    step(); #1;
    check_idle("eret_done");

    // Simultaneous exc and eret, then eret during EXC_FLUSH
    exc_req = 1; eret_req = 1; epc = 32'h0000_1234;
    step();
    exc_req = 0; eret_req = 1; epc = 32'h9000_0000; #1;
    check_redirect("both", EXC_VEC, 1'b1, 1'b1);
    step();
    eret_req = 0; #1;
    check_redirect("relatch", 32'h9000_0000, 1'b1, 1'b1);
    step(); #1;
    check_idle("relatch_done");

    // Asynchronous reset in the middle of BR_PEND
    branch_flag = 1; branch_addr = 32'h0000_6000;
    step();
    branch_flag = 0; stall_req_if = 1; #1;
    check_redirect("rstb", 32'h0000_6000, 1'b0, 1'b0);
    rst = 1; #1;
    check_idle("rstb_async");
    check("rstb_async.ds", {31'd0, in_delay_slot}, 32'd0);
    step();
    rst = 0; stall_req_if = 0;
    step(); #1;
    check_idle("rstb_release");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
